snn_step_sched: RTL

SNN_STEP_SCHED -- requirements
Module: snn_step_sched

---
 rtl/snn_step_sched_if.sv | 20 ++
 rtl/snn_step_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_step_sched_if.sv
// -----------------------------------------------------------------------------
// snn_step_sched_if
// Event-frame handshake between an event source (master) and the step
// scheduler (slave). One frame of F event bits moves on ev_valid & ev_ready.
//
// Signals:
//   ev_valid  source -> scheduler  frame on ev_data is valid
//   ev_ready  scheduler -> source  scheduler is waiting for a frame
//   ev_data   source -> scheduler  F-bit event frame
// -----------------------------------------------------------------------------
interface snn_step_sched_if #(
    parameter int F = 48
) ();
    logic         ev_valid;
    logic         ev_ready;
    logic [F-1:0] ev_data;

    modport master (output ev_valid, output ev_data, input ev_ready);
    modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/snn_step_sched.sv
// -----------------------------------------------------------------------------
// snn_step_sched
// Sequences one sample of a spiking network: T_STEPS times it fetches an
// event frame, pulses the core for one step, and accumulates the returned
// spikes into saturating per-neuron counters. It can optionally run an STDP
// sweep (F*N cycles) after every step, and ends by scanning the counters for
// the most active neuron.
//
// Optional feature: define SNN_SCHED_STDP_EN to build the LEARN state and the
// stdp_* drive. Without it learn_cfg is ignored and stdp_* are tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_start             begin a sample (only acted on while idle)
//   i_abort             cancel the current sample, no done pulse
//   i_learn_cfg         run STDP sweeps for this sample (captured at start)
//   o_busy, o_done      not-idle flag, one-cycle completion pulse
//   ev_if               event-frame handshake (slave side)
//   o_core_step         one-cycle clock enable for the core datapath
//   o_core_event_vec    captured event frame presented to the core
//   i_core_spikes       registered spike vector from the core
//   o_stdp_enable, o_stdp_pre_bits, o_stdp_post_bits   STDP engine control
//   o_spike_cnt         per-neuron counts, neuron n at [n*CNT_W +: CNT_W]
//   o_winner, o_win_valid  argmax neuron, high when any spike was counted
// -----------------------------------------------------------------------------
module snn_step_sched #(
    parameter  int F       = 48,
    parameter  int N       = 96,
    parameter  int T_STEPS = 32,
    parameter  int CNT_W   = 8,
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_learn_cfg,
    output logic               o_busy,
    output logic               o_done,
    snn_step_sched_if.slave    ev_if,
    output logic               o_core_step,
    output logic [F-1:0]       o_core_event_vec,
    input  logic [N-1:0]       i_core_spikes,
    output logic               o_stdp_enable,
    output logic [F-1:0]       o_stdp_pre_bits,
    output logic [N-1:0]       o_stdp_post_bits,
    output logic [N*CNT_W-1:0] o_spike_cnt,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_win_valid
);

    localparam int STEP_W = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_STEPS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
`ifdef SNN_SCHED_STDP_EN
    localparam int LRN_W = (F * N > 1) ? $clog2(F * N) : 1;
    localparam logic [LRN_W-1:0]  LAST_LRN  = LRN_W'(F * N - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_STEP,
        S_SAMPLE,
`ifdef SNN_SCHED_STDP_EN
        S_LEARN,
`endif
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [STEP_W-1:0]   r_stepIdx;
    logic [F-1:0]        r_frame;
    logic [N-1:0]        r_post;
    logic [N*CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]    r_winner;
    logic                r_winValid;
    logic [IDX_W-1:0]    r_scanIdx;
    logic [IDX_W-1:0]    r_bestIdx;
    logic [CNT_W-1:0]    r_bestCnt;
    logic                r_busy;
    logic                r_done;
    logic                r_evReady;
    logic                r_coreStep;
`ifdef SNN_SCHED_STDP_EN
    logic                r_learn;
    logic [LRN_W-1:0]    r_learnCnt;
    logic                r_stdpEn;
`endif

    logic [CNT_W-1:0]    w_curCnt;
    logic                w_better;

    // Counter under inspection during the argmax scan; a strictly greater
    // count is needed to displace the running best, so ties keep the lower index.
    assign w_curCnt = r_cnt[32'(r_scanIdx) * CNT_W +: CNT_W];
    assign w_better = (w_curCnt > r_bestCnt);

    // Whole sample sequencer. Outputs are registered and set on the edge that
    // enters the state they belong to. Abort outranks every transition, reset
    // outranks abort. Abort leaves counters and results untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_stepIdx  <= '0;
            r_frame    <= '0;
            r_post     <= '0;
            r_cnt      <= '0;
            r_winner   <= '0;
            r_winValid <= 1'b0;
            r_scanIdx  <= '0;
            r_bestIdx  <= '0;
            r_bestCnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_evReady  <= 1'b0;
            r_coreStep <= 1'b0;
`ifdef SNN_SCHED_STDP_EN
            r_learn    <= 1'b0;
            r_learnCnt <= '0;
            r_stdpEn   <= 1'b0;
`endif
        end else if (i_abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_evReady  <= 1'b0;
            r_coreStep <= 1'b0;
`ifdef SNN_SCHED_STDP_EN
            r_stdpEn   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_stepIdx  <= '0;
                        r_cnt      <= '0;
                        r_winner   <= '0;
                        r_winValid <= 1'b0;
                        r_busy     <= 1'b1;
                        r_evReady  <= 1'b1;
                        r_state    <= S_FETCH;
`ifdef SNN_SCHED_STDP_EN
                        r_learn    <= i_learn_cfg;
`endif
                    end
                end
                S_FETCH: begin
                    if (ev_if.ev_valid) begin
                        r_frame    <= ev_if.ev_data;
                        r_evReady  <= 1'b0;
                        r_coreStep <= 1'b1;
                        r_state    <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_coreStep <= 1'b0;
                    r_state    <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    for (int n = 0; n < N; n++) begin
                        if (i_core_spikes[n] && (r_cnt[n*CNT_W +: CNT_W] != CNT_MAX)) begin
                            r_cnt[n*CNT_W +: CNT_W] <= r_cnt[n*CNT_W +: CNT_W] + CNT_W'(1);
                        end
                    end
                    r_post <= i_core_spikes;
`ifdef SNN_SCHED_STDP_EN
                    if (r_learn) begin
                        r_learnCnt <= '0;
                        r_stdpEn   <= 1'b1;
                        r_state    <= S_LEARN;
                    end else
`endif
                    if (r_stepIdx < LAST_STEP) begin
                        r_stepIdx <= r_stepIdx + STEP_W'(1);
                        r_evReady <= 1'b1;
                        r_state   <= S_FETCH;
                    end else begin
                        r_scanIdx <= '0;
                        r_bestIdx <= '0;
                        r_bestCnt <= '0;
                        r_state   <= S_ARGMAX;
                    end
                end
`ifdef SNN_SCHED_STDP_EN
                S_LEARN: begin
                    if (r_learnCnt == LAST_LRN) begin
                        r_stdpEn <= 1'b0;
                        if (r_stepIdx < LAST_STEP) begin
                            r_stepIdx <= r_stepIdx + STEP_W'(1);
                            r_evReady <= 1'b1;
                            r_state   <= S_FETCH;
                        end else begin
                            r_scanIdx <= '0;
                            r_bestIdx <= '0;
                            r_bestCnt <= '0;
                            r_state   <= S_ARGMAX;
                        end
                    end else begin
                        r_learnCnt <= r_learnCnt + LRN_W'(1);
                    end
                end
`endif
                S_ARGMAX: begin
                    if (w_better) begin
                        r_bestCnt <= w_curCnt;
                        r_bestIdx <= r_scanIdx;
                    end
                    // The last neuron is folded in directly so the result is
                    // ready on the same edge that enters DONE.
                    if (r_scanIdx == LAST_IDX) begin
                        r_winner   <= w_better ? r_scanIdx : r_bestIdx;
                        r_winValid <= w_better || (r_bestCnt != '0);
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_scanIdx <= r_scanIdx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy     <= 1'b0;
                    r_evReady  <= 1'b0;
                    r_coreStep <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are masked by abort so the core and STDP engine never act on a
    // cycle that is being cancelled.
    assign ev_if.ev_ready   = r_evReady & ~i_abort;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_core_step      = r_coreStep & ~i_abort;
    assign o_core_event_vec = r_frame;
    assign o_spike_cnt      = r_cnt;
    assign o_winner         = r_winner;
    assign o_win_valid      = r_winValid;

`ifdef SNN_SCHED_STDP_EN
    assign o_stdp_enable    = r_stdpEn & ~i_abort;
    assign o_stdp_pre_bits  = r_stdpEn ? r_frame : '0;
    assign o_stdp_post_bits = r_stdpEn ? r_post  : '0;
`else
    logic w_unused;
    assign w_unused         = &{1'b0, i_learn_cfg, r_post};
    assign o_stdp_enable    = 1'b0;
    assign o_stdp_pre_bits  = '0;
    assign o_stdp_post_bits = '0;
`endif

endmodule
